mil_rt_responder: RTL and testbench

MIL_RT_RESPONDER -- requirements
Module: mil_rt_responder

---
 rtl/mil1553_pkg.sv | 38 +++
 rtl/mil_rt_buf.sv | 22 ++
 rtl/mil_rt_responder.sv | 178 +++++++++++++++++
 tb/tb_mil_rt_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mil1553_pkg.sv
// Shared definitions for the MIL-STD-1553 remote-terminal responder:
// command-word field positions, broadcast address, FSM state type and
// status-word layout.
package mil1553_pkg;

  // Command word fields
  localparam int unsigned CW_ADDR_HI = 15;
  localparam int unsigned CW_ADDR_LO = 11;
  localparam int unsigned CW_TR_BIT  = 10;
  localparam int unsigned CW_SA_HI   = 9;
  localparam int unsigned CW_SA_LO   = 5;
  localparam int unsigned CW_WC_HI   = 4;
  localparam int unsigned CW_WC_LO   = 0;

  localparam logic [4:0] BCAST_ADDR = 5'd31;
  localparam logic [4:0] SA_MODE_0  = 5'd0;
  localparam logic [4:0] SA_MODE_31 = 5'd31;

  // Status word: [15:11] terminal address, [10] message error, rest zero
  localparam int unsigned STS_ME_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_DATA,
    ST_GAP,
    ST_TX_STATUS,
    ST_TX_DATA
  } rt_state_e;

  function automatic logic [15:0] status_word(input logic [4:0] addr, input logic me);
    logic [15:0] w;
    w                        = '0;
    w[CW_ADDR_HI:CW_ADDR_LO] = addr;
    w[STS_ME_BIT]            = me;
    return w;
  endfunction

endpackage

// File: rtl/mil_rt_buf.sv
// 32x16 message buffer shared by all subaddresses.
// Ports: clk; wr_en/wr_addr/wr_dat synchronous write port;
//        rd_addr/rd_dat asynchronous read port.
// No reset: contents survive rst.
module mil_rt_buf (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_dat,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_dat
);

  logic [15:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/mil_rt_responder.sv
// MIL-STD-1553 remote-terminal message responder.
// Ports: clk, rst (sync, active-high);
//        rx_vld/rx_dat/rx_cw/rx_err  decoded word from receiver;
//        tx_dat/tx_en/tx_cw, tx_done word request handshake to transmitter;
//        busy (not IDLE), msg_err (sticky message-error status bit).
module mil_rt_responder
  import mil1553_pkg::*;
#(
  parameter logic [4:0]  RT_ADDR      = 5'd1,
  parameter int unsigned GAP_CLKS     = 200,
  parameter int unsigned TIMEOUT_CLKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_vld,
  input  logic [15:0] rx_dat,
  input  logic        rx_cw,
  input  logic        rx_err,
  output logic [15:0] tx_dat,
  output logic        tx_en,
  output logic        tx_cw,
  input  logic        tx_done,
  output logic        busy,
  output logic        msg_err
);

  localparam int unsigned TMR_MAX = (GAP_CLKS > TIMEOUT_CLKS) ? GAP_CLKS : TIMEOUT_CLKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  rt_state_e         state_q, state_d;
  logic              tr_q, tr_d, bcast_q, bcast_d, msg_err_q, msg_err_d;
  logic              tx_en_q, tx_en_d, tx_cw_q, tx_cw_d;
  logic [4:0]        cnt_q, cnt_d, idx_q, idx_d;
  logic [15:0]       tx_dat_q, tx_dat_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              buf_we;
  logic [15:0]       buf_rd;
  logic [4:0]        cw_addr, cw_sa, cw_wc;
  logic              cw_tr, cw_bcast, cw_mode, cmd_hit, data_ok, last_idx;

  assign cw_addr  = rx_dat[CW_ADDR_HI:CW_ADDR_LO];
  assign cw_tr    = rx_dat[CW_TR_BIT];
  assign cw_sa    = rx_dat[CW_SA_HI:CW_SA_LO];
  assign cw_wc    = rx_dat[CW_WC_HI:CW_WC_LO];
  assign cw_bcast = (cw_addr == BCAST_ADDR);
  assign cw_mode  = (cw_sa == SA_MODE_0) || (cw_sa == SA_MODE_31);
  assign cmd_hit  = rx_vld & rx_cw & ~rx_err & ((cw_addr == RT_ADDR) | cw_bcast);
  assign data_ok  = rx_vld & ~rx_cw & ~rx_err;
  // Count 0 encodes 32, so cnt-1 wraps to 31 and the last index falls out naturally.
  assign last_idx = (idx_q == (cnt_q - 5'd1));

  mil_rt_buf u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (idx_q),
    .wr_dat  (rx_dat),
    .rd_addr (idx_q),
    .rd_dat  (buf_rd)
  );

  always_comb begin
    state_d   = state_q;
    tr_d      = tr_q;
    bcast_d   = bcast_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmr_d     = '0;
    msg_err_d = msg_err_q;
    tx_en_d   = tx_en_q;
    tx_cw_d   = tx_cw_q;
    tx_dat_d  = tx_dat_q;
    buf_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_RX_DATA: begin
        tmr_d = tmr_q + 1'b1;
        if (data_ok) begin
          buf_we = 1'b1;
          tmr_d  = '0;
          if (last_idx) begin
            idx_d   = '0;
            state_d = bcast_q ? ST_IDLE : ST_GAP;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else if (!cmd_hit &&
                     ((rx_vld && (rx_err || rx_cw)) || (tmr_q == TMR_W'(TIMEOUT_CLKS - 1)))) begin
          msg_err_d = 1'b1;
          idx_d     = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_GAP: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TMR_W'(GAP_CLKS - 1)) begin
          tmr_d    = '0;
          tx_en_d  = 1'b1;
          tx_cw_d  = 1'b1;
          tx_dat_d = status_word(RT_ADDR, msg_err_q);
          state_d  = ST_TX_STATUS;
        end
      end
      ST_TX_STATUS: begin
        if (tx_en_q && tx_done) begin
          tx_en_d   = 1'b0;
          msg_err_d = 1'b0;
          idx_d     = '0;
          state_d   = tr_q ? ST_TX_DATA : ST_IDLE;
        end
      end
      ST_TX_DATA: begin
        // tx_en low for one clock between words; the word is latched on the rising clock.
        if (!tx_en_q) begin
          tx_en_d  = 1'b1;
          tx_cw_d  = 1'b0;
          tx_dat_d = buf_rd;
        end else if (tx_done) begin
          tx_en_d = 1'b0;
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A valid command for this terminal aborts whatever is in progress.
    if (cmd_hit) begin
      tx_en_d = 1'b0;
      idx_d   = '0;
      tmr_d   = '0;
      tr_d    = cw_tr & ~cw_mode;
      bcast_d = cw_bcast;
      cnt_d   = cw_wc;
      if (cw_bcast && (cw_tr || cw_mode)) state_d = ST_IDLE;
      else if (cw_mode || cw_tr)          state_d = ST_GAP;
      else                                state_d = ST_RX_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tr_q      <= 1'b0;
      bcast_q   <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      msg_err_q <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_cw_q   <= 1'b0;
      tx_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      tr_q      <= tr_d;
      bcast_q   <= bcast_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      msg_err_q <= msg_err_d;
      tx_en_q   <= tx_en_d;
      tx_cw_q   <= tx_cw_d;
      tx_dat_q  <= tx_dat_d;
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_cw   = tx_cw_q;
  assign tx_dat  = tx_dat_q;
  assign busy    = (state_q != ST_IDLE);
  assign msg_err = msg_err_q;

endmodule

// File: tb/tb_mil_rt_responder.sv
// Scoreboard bench for mil_rt_responder: the stimulus side decodes each
// command with plain arithmetic, keeps its own copy of the buffer and the
// message-error flag, and queues the words the terminal must transmit.
// A transmitter model pops and compares every word the DUT requests.
module tb_mil_rt_responder;

  localparam logic [4:0]  RT  = 5'd1;
  localparam int unsigned GAP = 200;
  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        rst, rx_vld, rx_cw, rx_err, tx_en, tx_cw, tx_done, busy, msg_err;
  logic [15:0] rx_dat, tx_dat;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mil_rt_responder #(.RT_ADDR(RT), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_cw(rx_cw),
    .rx_err(rx_err), .tx_dat(tx_dat), .tx_en(tx_en), .tx_cw(tx_cw),
    .tx_done(tx_done), .busy(busy), .msg_err(msg_err)
  );

  typedef struct { logic cw; logic [15:0] dat; } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  logic [15:0] pat[$];
  logic [15:0] model_mem [32];
  logic        model_me;
  int unsigned last_rx_cyc = 0;
  int unsigned data_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Transmitter model and monitor
  initial begin : monitor
    logic        seen;
    logic [15:0] cur;
    int unsigned hold, lowcnt;
    exp_t        e;
    seen = 1'b0; cur = '0; hold = 0; lowcnt = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
        seen = 1'b0; lowcnt = 0;
      end else if (tx_en) begin
        if (!seen) begin
          seen = 1'b1; cur = tx_dat; hold = $urandom_range(0, 3);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx: got %h cw=%b, expected no transmission", tx_dat, tx_cw);
          end else begin
            e = exp_q.pop_front();
            check("tx_word", {15'd0, tx_cw, tx_dat}, {15'd0, e.cw, e.dat});
            if (e.cw) check("status_gap", cyc - last_rx_cyc, GAP + 1);
            else begin
              check("interword_low", lowcnt, 1);
              data_cnt++;
            end
          end
          lowcnt = 0;
        end else begin
          check("tx_stable", {16'd0, tx_dat}, {16'd0, cur});
        end
        if (hold == 0) tx_done = 1'b1;
        else hold--;
      end else begin
        seen = 1'b0;
        lowcnt++;
        // Stray done pulses while idle must be ignored.
        tx_done = ($urandom_range(0, 7) == 0);
      end
    end
  end

  task automatic send(input logic cw, input logic [15:0] d, input logic err);
    @(negedge clk);
    rx_vld = 1'b1; rx_cw = cw; rx_dat = d; rx_err = err; last_rx_cyc = cyc;
    @(negedge clk);
    rx_vld = 1'b0; rx_cw = 1'b0; rx_err = 1'b0; rx_dat = 16'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic push_status();
    exp_t e;
    e.cw  = 1'b1;
    e.dat = 16'((int'(RT) * 2048) + (model_me ? 1024 : 0));
    exp_q.push_back(e);
    model_me = 1'b0;
  endtask

  task automatic push_data(input logic [15:0] d);
    exp_t e;
    e.cw = 1'b0; e.dat = d;
    exp_q.push_back(e);
  endtask

  // Reference behaviour of one complete command
  task automatic run_cmd(input logic [15:0] cw);
    int unsigned addr, tr, sa, n;
    logic [15:0] d;
    addr = cw / 2048; tr = (cw / 1024) % 2; sa = (cw / 32) % 32; n = cw % 32;
    if (n == 0) n = 32;
    send(1'b1, cw, 1'b0);
    if (addr != RT && addr != 31) return;
    if (sa == 0 || sa == 31) begin
      if (addr != 31) push_status();
      return;
    end
    if (tr == 1) begin
      if (addr != 31) begin
        push_status();
        for (int i = 0; i < int'(n); i++) push_data(model_mem[i]);
      end
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      if (pat.size() != 0) d = pat.pop_front();
      else d = 16'($urandom);
      send(1'b0, d, 1'b0);
      model_mem[i] = d;
    end
    if (addr != 31) push_status();
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, (busy || exp_q.size() != 0)}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] d, cw;
    int unsigned n, r, addr;
    rst = 1'b1; rx_vld = 1'b0; rx_cw = 1'b0; rx_err = 1'b0; rx_dat = '0;
    model_me = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_en", {31'd0, tx_en}, 0);
    check("rst_tx_cw", {31'd0, tx_cw}, 0);
    check("rst_tx_dat", {16'd0, tx_dat}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_msg_err", {31'd0, msg_err}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Receive two words, then transmit them back
    pat.push_back(16'h1234); pat.push_back(16'h5678);
    run_cmd(16'h0822); wait_idle("rx2");
    run_cmd(16'h0C22); wait_idle("tx2");

    // Non-matching address ignored in IDLE
    run_cmd(16'h1022);
    check("wrong_addr_busy", {31'd0, busy}, 0);
    wait_idle("wrong_addr");

    // Timeout after one of two data words
    send(1'b1, 16'h0822, 1'b0);
    d = 16'($urandom);
    send(1'b0, d, 1'b0);
    model_mem[0] = d;
    while (cyc < last_rx_cyc + TMO) @(negedge clk);
    check("timeout_busy_before", {31'd0, busy}, 1);
    @(negedge clk);
    check("timeout_busy_after", {31'd0, busy}, 0);
    model_me = 1'b1;
    check("timeout_msg_err", {31'd0, msg_err}, {31'd0, model_me});
    run_cmd(16'h0C21); wait_idle("tx_after_timeout");
    check("msg_err_cleared", {31'd0, msg_err}, 0);

    // Broadcast receive: buffered, no status
    pat.push_back(16'hABCD);
    run_cmd(16'hF821); wait_idle("bcast");
    run_cmd(16'h0C21); wait_idle("tx_after_bcast");

    // Error on the second data word
    send(1'b1, 16'h0822, 1'b0);
    d = 16'($urandom);
    send(1'b0, d, 1'b0);
    model_mem[0] = d;
    send(1'b0, 16'($urandom), 1'b1);
    model_me = 1'b1;
    wait_idle("rx_err");
    check("rx_err_msg_err", {31'd0, msg_err}, 1);

    // Full 32-word receive and transmit
    run_cmd(16'h0820); wait_idle("rx32");
    run_cmd(16'h0C20); wait_idle("tx32");

    // Reset during the 32-word transmit
    data_cnt = 0;
    run_cmd(16'h0C20);
    n = 0;
    while (data_cnt < 10 && n < 5000) begin @(negedge clk); n++; end
    check("reach_word10", {31'd0, (data_cnt >= 10)}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_en", {31'd0, tx_en}, 0);
    check("mid_rst_tx_cw", {31'd0, tx_cw}, 0);
    check("mid_rst_tx_dat", {16'd0, tx_dat}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_msg_err", {31'd0, msg_err}, 0);
    rst = 1'b0;
    exp_q.delete();
    model_me = 1'b0;
    @(negedge clk);
    run_cmd(16'h0C20); wait_idle("tx32_after_rst");

    // New command aborts a receive in progress
    send(1'b1, 16'h0822, 1'b0);
    d = 16'($urandom);
    send(1'b0, d, 1'b0);
    model_mem[0] = d;
    run_cmd(16'h0C21); wait_idle("abort");
    check("abort_msg_err", {31'd0, msg_err}, 0);

    // Mode codes: status only
    run_cmd(16'h0C05); wait_idle("mode0");
    run_cmd(16'h0BE3); wait_idle("mode31");

    // Random commands
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 9);
      addr = (r < 6) ? int'(RT) : ((r < 8) ? 31 : $urandom_range(2, 30));
      cw = 16'((addr * 2048) + ($urandom_range(0, 1) * 1024) +
               ($urandom_range(0, 31) * 32) + $urandom_range(0, 31));
      run_cmd(cw); wait_idle("random");
      check("random_msg_err", {31'd0, msg_err}, {31'd0, model_me});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
